// File: rtl/io_read_pkg.sv
// Shared definitions for the I/O read hub: default sizes, channel index
// names and the select-vector classifier used by the read decode.
package io_read_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 4;
  localparam int MAX_CH     = 8;

  // Board channel assignment
  localparam int CH_SWITCH = 0;
  localparam int CH_KEYPAD = 1;
  localparam int CH_BUTTON = 2;
  localparam int CH_SPARE  = 3;

  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_ONEHOT = 2'd1,
    SEL_MULTI  = 2'd2
  } sel_class_e;

  // Classify a (zero-extended) channel select as none, exactly one, or several bits set
  function automatic sel_class_e is_onehot(input logic [MAX_CH-1:0] vec);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < MAX_CH; i++) begin
      ones = ones + {3'd0, vec[i]};
    end
    if (ones == 4'd0) begin
      return SEL_ZERO;
    end else if (ones == 4'd1) begin
      return SEL_ONEHOT;
    end else begin
      return SEL_MULTI;
    end
  endfunction

endpackage

// File: rtl/io_chan_filter.sv
// One input channel of the I/O read hub: two-flop synchroniser feeding a
// stable-value register, with an optional debounce counter in between.
// Build option: IOREAD_DEBOUNCE_EN enables the debounce counter; without
// it the stable value simply follows the synchronised input.
module io_chan_filter
  import io_read_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W
`ifdef IOREAD_DEBOUNCE_EN
  ,
  parameter int DEB_LIMIT = 1000000,
  parameter int DEB_CNT_W = 20
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] stable,
  output logic              change
);

  logic [DATA_W-1:0] sync1;
  logic [DATA_W-1:0] sync2;
  logic [DATA_W-1:0] stable_d;

  // Two-flop synchroniser on every bit of the asynchronous device input
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef IOREAD_DEBOUNCE_EN
  logic [DEB_CNT_W-1:0] cnt;
  logic                 differs;
  logic                 cnt_hit;

  assign differs = (sync2 != stable);
  assign cnt_hit = (cnt == DEB_CNT_W'(DEB_LIMIT - 1));

  // Accept the synchronised value only once it has differed for DEB_LIMIT clocks in a row
  always_comb begin
    stable_d = stable;
    if (differs && cnt_hit) begin
      stable_d = sync2;
    end
  end

  // Count consecutive clocks of disagreement; any agreement restarts the window
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!differs || cnt_hit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DEB_CNT_W'(1);
    end
  end
`else
  // Without debounce the stable value tracks the synchroniser directly
  always_comb begin
    stable_d = sync2;
  end
`endif

  // Stable-value register presented to the read mux
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
    end else begin
      stable <= stable_d;
    end
  end

  // High in the cycle before stable updates, so the event flag sets on the same edge
  assign change = (stable_d != stable);

endmodule

// File: rtl/io_read_hub.sv
// Multi-channel I/O read hub: per-channel filtered inputs, sticky change
// flags, one-hot select decode and a registered read-data port.
// Build option: IOREAD_DEBOUNCE_EN enables per-channel debounce counters.
module io_read_hub
  import io_read_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int DEB_LIMIT = 1000000,
  parameter int DEB_CNT_W = 20
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     ior,
  input  logic [NUM_CH-1:0]        ch_sel,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [DATA_W-1:0]        ioread_data,
  output logic                     rdata_valid,
  output logic [NUM_CH-1:0]        ch_event,
  output logic                     sel_err
);

  logic [DATA_W-1:0] stable_arr [NUM_CH];
  logic [NUM_CH-1:0] change_vec;
  sel_class_e        sel_class;
  logic              read_ok;
  logic [NUM_CH-1:0] clr_mask;
  logic [DATA_W-1:0] read_word;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    io_chan_filter #(
      .DATA_W    (DATA_W)
`ifdef IOREAD_DEBOUNCE_EN
      ,
      .DEB_LIMIT (DEB_LIMIT),
      .DEB_CNT_W (DEB_CNT_W)
`endif
    ) u_filter (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (ch_data[k*DATA_W +: DATA_W]),
      .stable  (stable_arr[k]),
      .change  (change_vec[k])
    );
  end

  assign sel_class = is_onehot(MAX_CH'(ch_sel));
  assign read_ok   = ior && (sel_class == SEL_ONEHOT);
  assign clr_mask  = read_ok ? ch_sel : '0;

  // AND-OR mux of the stable values; valid because only a one-hot select is ever used
  always_comb begin
    read_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      read_word = read_word | (stable_arr[k] & {DATA_W{ch_sel[k]}});
    end
  end

  // Registered read port, strobe pulses and sticky change flags (a new change beats a clear)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ioread_data <= '0;
      rdata_valid <= 1'b0;
      sel_err     <= 1'b0;
      ch_event    <= '0;
    end else begin
      rdata_valid <= read_ok;
      sel_err     <= ior && (sel_class == SEL_MULTI);
      if (read_ok) begin
        ioread_data <= read_word;
      end
      ch_event <= (ch_event & ~clr_mask) | change_vec;
    end
  end

endmodule

// File: tb/tb_io_read_hub.sv
// Directed bench for io_read_hub: reset, change latency, read port,
// select errors, set/clear collision, back-to-back reads and, when built
// with IOREAD_DEBOUNCE_EN, glitch rejection.
module tb_io_read_hub;
  import io_read_pkg::*;

  localparam int DATA_W    = 16;
  localparam int NUM_CH    = 4;
  localparam int DEB_LIMIT = 4;
  localparam int DEB_CNT_W = 3;
`ifdef IOREAD_DEBOUNCE_EN
  localparam int LAT = DEB_LIMIT + 2;
`else
  localparam int LAT = 3;
`endif

  logic                     clock;
  logic                     reset_n;
  logic                     ior;
  logic [NUM_CH-1:0]        ch_sel;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [DATA_W-1:0]        ioread_data;
  logic                     rdata_valid;
  logic [NUM_CH-1:0]        ch_event;
  logic                     sel_err;

  int total;
  int bad;

  typedef struct {
    logic              ior;
    logic [NUM_CH-1:0] sel;
    logic [DATA_W-1:0] exp_data;
    logic              exp_valid;
    logic              exp_err;
    logic [NUM_CH-1:0] exp_event;
    string             name;
  } vec_t;

  vec_t vecs [8];

  io_read_hub #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .DEB_LIMIT (DEB_LIMIT),
    .DEB_CNT_W (DEB_CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ior         (ior),
    .ch_sel      (ch_sel),
    .ch_data     (ch_data),
    .ioread_data (ioread_data),
    .rdata_valid (rdata_valid),
    .ch_event    (ch_event),
    .sel_err     (sel_err)
  );

  // Free-running 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [DATA_W-1:0] val);
    ch_data[k*DATA_W +: DATA_W] = val;
  endtask

  task automatic applyStimulus(input vec_t v);
    ior    = v.ior;
    ch_sel = v.sel;
    step(1);
    checkOutput({v.name, ".data"},  32'(ioread_data), 32'(v.exp_data));
    checkOutput({v.name, ".valid"}, 32'(rdata_valid), 32'(v.exp_valid));
    checkOutput({v.name, ".err"},   32'(sel_err),     32'(v.exp_err));
    checkOutput({v.name, ".event"}, 32'(ch_event),    32'(v.exp_event));
  endtask

  initial begin
    vec_t v;
    logic [NUM_CH-1:0] ev_mask;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    ior     = 1'b1;
    ch_sel  = 4'b0001;
    ch_data = {NUM_CH{16'hFFFF}};

    // Reset holds every output low even with a read strobe present
    repeat (5) begin
      @(negedge clock);
      checkOutput("rst.data",  32'(ioread_data), 32'h0);
      checkOutput("rst.valid", 32'(rdata_valid), 32'h0);
      checkOutput("rst.event", 32'(ch_event),    32'h0);
      checkOutput("rst.err",   32'(sel_err),     32'h0);
    end
    ior    = 1'b0;
    ch_sel = '0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // All-ones inputs reach the stable values LAT clocks after release
    step(LAT - 1);
    checkOutput("post_rst.event_early", 32'(ch_event),    32'h0);
    checkOutput("post_rst.data",        32'(ioread_data), 32'h0);
    checkOutput("post_rst.valid",       32'(rdata_valid), 32'h0);
    step(1);
    checkOutput("post_rst.event", 32'(ch_event), 32'hF);

    // Clear the reset-induced events, one channel per cycle
    for (int k = 0; k < NUM_CH; k++) begin
      ev_mask     = 4'hF;
      ev_mask     = ev_mask << (k + 1);
      v.ior       = 1'b1;
      v.sel       = 4'b0001 << k;
      v.exp_data  = 16'hFFFF;
      v.exp_valid = 1'b1;
      v.exp_err   = 1'b0;
      v.exp_event = ev_mask;
      v.name      = $sformatf("clear%0d", k);
      applyStimulus(v);
    end
    applyStimulus('{1'b0, 4'b0000, 16'hFFFF, 1'b0, 1'b0, 4'b0000, "idle0"});

    // Switch channel change: event after LAT clocks, read two cycles later
    set_ch(CH_SWITCH, 16'h00A5);
    step(LAT - 1);
    checkOutput("sw.event_early", 32'(ch_event), 32'h0);
    step(1);
    checkOutput("sw.event", 32'(ch_event), 32'h1);
    step(1);
    applyStimulus('{1'b1, 4'b0001, 16'h00A5, 1'b1, 1'b0, 4'b0000, "sw.read"});
    applyStimulus('{1'b0, 4'b0000, 16'h00A5, 1'b0, 1'b0, 4'b0000, "sw.idle"});

    // Distinct values on the other channels, then the table of reads
    set_ch(CH_KEYPAD, 16'h1234);
    set_ch(CH_BUTTON, 16'h5678);
    set_ch(CH_SPARE,  16'h9ABC);
    step(LAT + 1);

    vecs[0] = '{1'b1, 4'b0101, 16'h00A5, 1'b0, 1'b1, 4'b1110, "multi_hot"};
    vecs[1] = '{1'b1, 4'b0000, 16'h00A5, 1'b0, 1'b0, 4'b1110, "zero_sel"};
    vecs[2] = '{1'b1, 4'(1 << CH_SWITCH), 16'h00A5, 1'b1, 1'b0, 4'b1110, "b2b_sw"};
    vecs[3] = '{1'b1, 4'(1 << CH_KEYPAD), 16'h1234, 1'b1, 1'b0, 4'b1100, "b2b_key"};
    vecs[4] = '{1'b1, 4'(1 << CH_BUTTON), 16'h5678, 1'b1, 1'b0, 4'b1000, "b2b_btn"};
    vecs[5] = '{1'b1, 4'(1 << CH_SPARE),  16'h9ABC, 1'b1, 1'b0, 4'b0000, "b2b_spare"};
    vecs[6] = '{1'b0, 4'b0001, 16'h9ABC, 1'b0, 1'b0, 4'b0000, "ior_low"};
    vecs[7] = '{1'b0, 4'b0000, 16'h9ABC, 1'b0, 1'b0, 4'b0000, "idle1"};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Read issued in the cycle the keypad stable value changes: old data, flag kept
    set_ch(CH_KEYPAD, 16'h4321);
    step(LAT - 1);
    applyStimulus('{1'b1, 4'b0010, 16'h1234, 1'b1, 1'b0, 4'b0010, "collide.read1"});
    applyStimulus('{1'b1, 4'b0010, 16'h4321, 1'b1, 1'b0, 4'b0000, "collide.read2"});
    applyStimulus('{1'b0, 4'b0000, 16'h4321, 1'b0, 1'b0, 4'b0000, "collide.idle"});

`ifdef IOREAD_DEBOUNCE_EN
    // A pulse shorter than the debounce window must never surface
    set_ch(CH_BUTTON, 16'h5679);
    step(3);
    set_ch(CH_BUTTON, 16'h5678);
    for (int i = 0; i < 10; i++) begin
      step(1);
      checkOutput($sformatf("glitch.event%0d", i), 32'(ch_event), 32'h0);
    end
`endif

    // A held change on the button channel lands exactly LAT clocks after the edge
    set_ch(CH_BUTTON, 16'h5679);
    step(LAT - 1);
    checkOutput("held.event_early", 32'(ch_event), 32'h0);
    step(1);
    checkOutput("held.event", 32'(ch_event), 32'h4);
    applyStimulus('{1'b1, 4'b0100, 16'h5679, 1'b1, 1'b0, 4'b0000, "held.read"});
    applyStimulus('{1'b0, 4'b0000, 16'h5679, 1'b0, 1'b0, 4'b0000, "held.idle"});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
